pipe_core_5stage: RTL and testbench

//  Parametrised 5-stage (IF/ID/EX/MEM/WB) in-order core; successor to the 4-stage ADD/SUB/LOAD core.

---
 rtl/pipe_core_pkg.sv | 48 ++++
 rtl/pipe_core_hazard.sv | 59 +++++
 rtl/pipe_core_5stage.sv | 168 ++++++++++++++++
 tb/tb_pipe_core_5stage.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_core_pkg.sv
// rtl/pipe_core_pkg.sv - opcodes, forward selects and decode helpers shared by the 5-stage core
package pipe_core_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_LOAD  = 4'd3;
  localparam logic [3:0] OP_STORE = 4'd4;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_JMP   = 4'd8;
  localparam logic [3:0] OP_HALT  = 4'd15;

  // A bubble is an all-zero stage register, which decodes as NOP.
  localparam logic [3:0] BUBBLE_OP = OP_NOP;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  function automatic logic [3:0] decode_op(input logic [3:0] raw);
    if (raw <= OP_JMP || raw == OP_HALT) return raw;
    return OP_NOP;
  endfunction

  function automatic logic writes_rd(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_LOAD, OP_AND, OP_OR, OP_XOR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic reads_rs1(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_STORE, OP_AND, OP_OR, OP_XOR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic reads_rs2(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_core_hazard.sv
// rtl/pipe_core_hazard.sv - RAW interlock and EX operand forward selects; FORWARD_EN enables forwarding
module pipe_core_hazard
  import pipe_core_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic [3:0]        id_op,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [3:0]        ex_op,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [3:0]        mem_op,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [3:0]        wb_op,
  input  logic [REG_AW-1:0] wb_rd,
  output logic              stall,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  logic use_a, use_b, ex_hit, mem_hit;

  always_comb begin
    use_a   = reads_rs1(id_op);
    use_b   = reads_rs2(id_op);
    ex_hit  = writes_rd(ex_op) && ((use_a && ex_rd == id_rs1) || (use_b && ex_rd == id_rs2));
    mem_hit = writes_rd(mem_op) && ((use_a && mem_rd == id_rs1) || (use_b && mem_rd == id_rs2));
  end

`ifdef FORWARD_EN
  logic mem_fwd_ok, wb_fwd_ok, unused_mem_hit;

  // Load data only exists after MEM, so EX/MEM forwarding covers ALU results only.
  assign mem_fwd_ok     = writes_rd(mem_op) && mem_op != OP_LOAD;
  assign wb_fwd_ok      = writes_rd(wb_op);
  assign stall          = ex_hit && ex_op == OP_LOAD;
  assign unused_mem_hit = mem_hit;

  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (mem_fwd_ok && mem_rd == ex_rs1)     fwd_a = FWD_MEM;
    else if (wb_fwd_ok && wb_rd == ex_rs1)  fwd_a = FWD_WB;
    if (mem_fwd_ok && mem_rd == ex_rs2)     fwd_b = FWD_MEM;
    else if (wb_fwd_ok && wb_rd == ex_rs2)  fwd_b = FWD_WB;
  end
`else
  logic unused_fwd_inputs;

  // WB needs no interlock: the register file read is write-through.
  assign stall             = ex_hit || mem_hit;
  assign fwd_a             = FWD_RF;
  assign fwd_b             = FWD_RF;
  assign unused_fwd_inputs = ^{ex_rs1, ex_rs2, wb_op, wb_rd};
`endif

endmodule

// File: rtl/pipe_core_5stage.sv
// rtl/pipe_core_5stage.sv - 5-stage IF/ID/EX/MEM/WB in-order core; FORWARD_EN selects forwarding build
module pipe_core_5stage
  import pipe_core_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int REG_AW  = 4,
  parameter  int PC_W    = 8,
  localparam int INSTR_W = 4 + 3 * REG_AW
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [REG_AW-1:0]  dmem_addr,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               wb_valid,
  output logic [REG_AW-1:0]  wb_rd,
  output logic [DATA_W-1:0]  wb_data,
  output logic               stall,
  output logic               halted
);

  localparam int NREG = 1 << REG_AW;

  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ifid_instr;
  logic               halt_pend, halted_q;
  logic [3:0]         idex_op, exmem_op, memwb_op;
  logic [REG_AW-1:0]  idex_rd, idex_rs1, idex_rs2, exmem_rd, exmem_addr, memwb_rd;
  logic [DATA_W-1:0]  idex_a, idex_b, exmem_res, memwb_data;
  logic [DATA_W-1:0]  rf [NREG];

  logic [3:0]         id_op;
  logic [REG_AW-1:0]  id_rd, id_rs1, id_rs2;
  logic [INSTR_W-5:0] id_jfield;
  logic [DATA_W-1:0]  id_a, id_b, op_a, op_b, ex_res;
  logic [1:0]         fwd_a, fwd_b;
  logic               wb_we, mem_ld, mem_st;

  assign id_op     = decode_op(ifid_instr[INSTR_W-1 -: 4]);
  assign id_rd     = ifid_instr[INSTR_W-5 -: REG_AW];
  assign id_rs1    = ifid_instr[INSTR_W-5-REG_AW -: REG_AW];
  assign id_rs2    = ifid_instr[REG_AW-1:0];
  assign id_jfield = ifid_instr[INSTR_W-5:0];

  assign wb_we = writes_rd(memwb_op);
  assign id_a  = (wb_we && memwb_rd == id_rs1) ? memwb_data : rf[id_rs1];
  assign id_b  = (wb_we && memwb_rd == id_rs2) ? memwb_data : rf[id_rs2];

  pipe_core_hazard #(.REG_AW(REG_AW)) u_hazard (
    .id_op  (id_op),
    .id_rs1 (id_rs1),
    .id_rs2 (id_rs2),
    .ex_op  (idex_op),
    .ex_rd  (idex_rd),
    .ex_rs1 (idex_rs1),
    .ex_rs2 (idex_rs2),
    .mem_op (exmem_op),
    .mem_rd (exmem_rd),
    .wb_op  (memwb_op),
    .wb_rd  (memwb_rd),
    .stall  (stall),
    .fwd_a  (fwd_a),
    .fwd_b  (fwd_b)
  );

  always_comb begin
    op_a = idex_a;
    op_b = idex_b;
    if (fwd_a == FWD_MEM)     op_a = exmem_res;
    else if (fwd_a == FWD_WB) op_a = memwb_data;
    if (fwd_b == FWD_MEM)     op_b = exmem_res;
    else if (fwd_b == FWD_WB) op_b = memwb_data;
    ex_res = '0;
    case (idex_op)
      OP_ADD:   ex_res = op_a + op_b;
      OP_SUB:   ex_res = op_a - op_b;
      OP_AND:   ex_res = op_a & op_b;
      OP_OR:    ex_res = op_a | op_b;
      OP_XOR:   ex_res = op_a ^ op_b;
      OP_STORE: ex_res = op_a;
      default:  ex_res = '0;
    endcase
  end

  assign mem_ld     = exmem_op == OP_LOAD;
  assign mem_st     = exmem_op == OP_STORE;
  assign dmem_we    = mem_st;
  assign dmem_addr  = (mem_ld || mem_st) ? exmem_addr : '0;
  assign dmem_wdata = mem_st ? exmem_res : '0;

  // Fetch: stall holds PC and IF/ID; HALT freezes PC and bubbles IF/ID from then on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= '0;
      ifid_instr <= '0;
      halt_pend  <= 1'b0;
    end else if (!stall) begin
      if (halt_pend || id_op == OP_HALT) begin
        halt_pend  <= 1'b1;
        ifid_instr <= '0;
      end else if (id_op == OP_JMP) begin
        pc         <= PC_W'(id_jfield);
        ifid_instr <= '0;
      end else begin
        pc         <= pc + PC_W'(1);
        ifid_instr <= imem_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || stall) begin
      idex_op  <= BUBBLE_OP;
      idex_rd  <= '0;
      idex_rs1 <= '0;
      idex_rs2 <= '0;
      idex_a   <= '0;
      idex_b   <= '0;
    end else begin
      idex_op  <= id_op;
      idex_rd  <= id_rd;
      idex_rs1 <= id_rs1;
      idex_rs2 <= id_rs2;
      idex_a   <= id_a;
      idex_b   <= id_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exmem_op   <= BUBBLE_OP;
      exmem_rd   <= '0;
      exmem_addr <= '0;
      exmem_res  <= '0;
      memwb_op   <= BUBBLE_OP;
      memwb_rd   <= '0;
      memwb_data <= '0;
      halted_q   <= 1'b0;
    end else begin
      exmem_op   <= idex_op;
      exmem_rd   <= idex_rd;
      exmem_addr <= idex_rs2;
      exmem_res  <= ex_res;
      memwb_op   <= exmem_op;
      memwb_rd   <= writes_rd(exmem_op) ? exmem_rd : '0;
      memwb_data <= mem_ld ? dmem_rdata : exmem_res;
      halted_q   <= halted_q || memwb_op == OP_HALT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_we) begin
      rf[memwb_rd] <= memwb_data;
    end
  end

  assign imem_addr = pc;
  assign wb_valid  = wb_we;
  assign wb_rd     = wb_we ? memwb_rd : '0;
  assign wb_data   = wb_we ? memwb_data : '0;
  assign halted    = halted_q || memwb_op == OP_HALT;

endmodule

// File: tb/tb_pipe_core_5stage.sv
// tb/tb_pipe_core_5stage.sv - directed self-checking bench for pipe_core_5stage (default and FORWARD_EN builds)
module tb_pipe_core_5stage;

  logic        clk, rst;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic [3:0]  dmem_addr;
  logic        dmem_we;
  logic [7:0]  dmem_wdata, dmem_rdata;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [7:0]  wb_data;
  logic        stall, halted;

  logic [15:0] imem [256];
  logic [7:0]  dmem [16];
  logic [7:0]  dm_init [16];
  logic        dm_load;

  logic [3:0]  ret_rd [$];
  logic [7:0]  ret_data [$];
  int          stall_cnt, we_cnt, cyc, first_ret;
  int          tests, failed;

  pipe_core_5stage #(.DATA_W(8), .REG_AW(4), .PC_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .dmem_addr  (dmem_addr),
    .dmem_we    (dmem_we),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .stall      (stall),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rdata = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clk) begin
    if (dm_load) begin
      for (int i = 0; i < 16; i++) dmem[i] <= dm_init[i];
    end else if (dmem_we) begin
      dmem[dmem_addr] <= dmem_wdata;
    end
  end

  always @(negedge clk) begin
    if (dmem_we) we_cnt++;
    if (rst) begin
      cyc       = 0;
      first_ret = 0;
    end else begin
      cyc++;
      if (stall) stall_cnt++;
      if (wb_valid) begin
        ret_rd.push_back(wb_rd);
        ret_data.push_back(wb_data);
        if (first_ret == 0) first_ret = cyc;
      end
    end
  end

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
  endtask

  task automatic start_prog();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_halt(output bit ok);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
    end
    ok = (halted === 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({wb_valid, wb_rd, wb_data, dmem_we, dmem_addr, dmem_wdata, stall, halted} !== '0) begin
      failed++;
      $display("FAIL reset_outputs: got %b required all 0",
               {wb_valid, wb_rd, wb_data, dmem_we, dmem_addr, dmem_wdata, stall, halted});
    end
    tests++;
    if (imem_addr !== 8'd0) begin
      failed++;
      $display("FAIL reset_imem_addr: got %0d required 0", imem_addr);
    end
    @(posedge clk); #1 rst = 1'b0; dm_load = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); @(negedge clk);
      tests++;
      if (imem_addr !== 8'(i)) begin
        failed++;
        $display("FAIL fetch_seq: imem_addr got %0d required %0d", imem_addr, i);
      end
    end
  endtask

  task automatic test_load_use();
    logic [3:0] exp_rd [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    logic [7:0] exp_d  [5] = '{8'd5, 8'd7, 8'd12, 8'd24, 8'd12};
    int base, st0, exp_st;
    bit ok;
`ifdef FORWARD_EN
    exp_st = 1;
`else
    exp_st = 6;
`endif
    clear_imem();
    imem[0] = 16'h3102; imem[1] = 16'h3203; imem[2] = 16'h1312;
    imem[3] = 16'h1433; imem[4] = 16'h2543; imem[5] = 16'hF000;
    start_prog();
    base = ret_rd.size(); st0 = stall_cnt;
    wait_halt(ok);
    tests++;
    if (!ok) begin failed++; $display("FAIL load_use_halt: halted got 0 required 1"); end
    tests++;
    if (first_ret !== 5) begin
      failed++;
      $display("FAIL first_retire_cycle: got %0d required 5", first_ret);
    end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (base + i >= ret_rd.size()) begin
        failed++;
        $display("FAIL load_use_retire%0d: missing, required r%0d=%0d", i, exp_rd[i], exp_d[i]);
      end else if (ret_rd[base+i] !== exp_rd[i] || ret_data[base+i] !== exp_d[i]) begin
        failed++;
        $display("FAIL load_use_retire%0d: got r%0d=%0d required r%0d=%0d", i,
                 ret_rd[base+i], ret_data[base+i], exp_rd[i], exp_d[i]);
      end
    end
    tests++;
    if (ret_rd.size() - base != 5) begin
      failed++;
      $display("FAIL load_use_count: got %0d required 5", ret_rd.size() - base);
    end
    tests++;
    if (stall_cnt - st0 != exp_st) begin
      failed++;
      $display("FAIL load_use_stalls: got %0d required %0d", stall_cnt - st0, exp_st);
    end
  endtask

  task automatic test_wrap_logic();
    logic [3:0] exp_rd [7] = '{4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
    logic [7:0] exp_d  [7] = '{8'd200, 8'd100, 8'd44, 8'd156, 8'd64, 8'd236, 8'd172};
    int base;
    bit ok;
    clear_imem();
    imem[0] = 16'h3100; imem[1] = 16'h3201; imem[2] = 16'h1612; imem[3] = 16'h2721;
    imem[4] = 16'h5812; imem[5] = 16'h6912; imem[6] = 16'h7A12; imem[7] = 16'hF000;
    start_prog();
    base = ret_rd.size();
    wait_halt(ok);
    tests++;
    if (!ok) begin failed++; $display("FAIL wrap_halt: halted got 0 required 1"); end
    for (int i = 0; i < 7; i++) begin
      tests++;
      if (base + i >= ret_rd.size()) begin
        failed++;
        $display("FAIL wrap_retire%0d: missing, required r%0d=%0d", i, exp_rd[i], exp_d[i]);
      end else if (ret_rd[base+i] !== exp_rd[i] || ret_data[base+i] !== exp_d[i]) begin
        failed++;
        $display("FAIL wrap_retire%0d: got r%0d=%0d required r%0d=%0d", i,
                 ret_rd[base+i], ret_data[base+i], exp_rd[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_jump_store();
    logic [3:0] exp_rd [4] = '{4'd1, 4'd2, 4'd3, 4'd12};
    logic [7:0] exp_d  [4] = '{8'd5, 8'd7, 8'd12, 8'd17};
    int base, we0;
    bit ok;
    clear_imem();
    imem[0] = 16'h3102; imem[1] = 16'h3203; imem[2] = 16'h1312; imem[3] = 16'h0000;
    imem[4] = 16'h8010; imem[5] = 16'h1B11; imem[6] = 16'hF000;
    imem[16] = 16'h4039; imem[17] = 16'h1C31; imem[18] = 16'hF000;
    start_prog();
    base = ret_rd.size(); we0 = we_cnt;
    wait_halt(ok);
    tests++;
    if (!ok) begin failed++; $display("FAIL jump_halt: halted got 0 required 1"); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (base + i >= ret_rd.size()) begin
        failed++;
        $display("FAIL jump_retire%0d: missing, required r%0d=%0d", i, exp_rd[i], exp_d[i]);
      end else if (ret_rd[base+i] !== exp_rd[i] || ret_data[base+i] !== exp_d[i]) begin
        failed++;
        $display("FAIL jump_retire%0d: got r%0d=%0d required r%0d=%0d", i,
                 ret_rd[base+i], ret_data[base+i], exp_rd[i], exp_d[i]);
      end
    end
    tests++;
    if (ret_rd.size() - base != 4) begin
      failed++;
      $display("FAIL jump_count: got %0d required 4", ret_rd.size() - base);
    end
    tests++;
    if (dmem[9] !== 8'd12) begin
      failed++;
      $display("FAIL store_dmem9: got %0d required 12", dmem[9]);
    end
    tests++;
    if (we_cnt - we0 != 1) begin
      failed++;
      $display("FAIL store_we_count: got %0d required 1", we_cnt - we0);
    end
  endtask

  task automatic test_halt();
    logic [3:0] exp_rd [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
    logic [7:0] exp_d  [4] = '{8'd5, 8'd10, 8'd15, 8'd5};
    int base;
    bit ok;
    clear_imem();
    imem[0] = 16'h3102; imem[1] = 16'h1211; imem[2] = 16'h7321; imem[3] = 16'h0000;
    imem[4] = 16'h0000; imem[5] = 16'h6411; imem[6] = 16'hF000; imem[7] = 16'h1511;
    imem[8] = 16'h1611;
    start_prog();
    base = ret_rd.size();
    wait_halt(ok);
    tests++;
    if (!ok) begin failed++; $display("FAIL halt_seen: halted got 0 required 1"); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (base + i >= ret_rd.size()) begin
        failed++;
        $display("FAIL halt_retire%0d: missing, required r%0d=%0d", i, exp_rd[i], exp_d[i]);
      end else if (ret_rd[base+i] !== exp_rd[i] || ret_data[base+i] !== exp_d[i]) begin
        failed++;
        $display("FAIL halt_retire%0d: got r%0d=%0d required r%0d=%0d", i,
                 ret_rd[base+i], ret_data[base+i], exp_rd[i], exp_d[i]);
      end
    end
    tests++;
    if (ret_rd.size() - base != 4) begin
      failed++;
      $display("FAIL halt_count: got %0d required 4", ret_rd.size() - base);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (imem_addr !== 8'd7 || halted !== 1'b1) begin
        failed++;
        $display("FAIL halt_frozen: imem_addr=%0d halted=%0b required 7 and 1", imem_addr, halted);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [3:0] exp_rd [1] = '{4'd13};
    logic [7:0] exp_d  [1] = '{8'd0};
    int base, we0;
    bit ok;
    clear_imem();
    imem[0] = 16'h3102; imem[1] = 16'h4139; imem[2] = 16'h1312; imem[3] = 16'hF000;
    start_prog();
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({wb_valid, wb_rd, wb_data, dmem_we, dmem_addr, dmem_wdata, stall, halted, imem_addr} !== '0) begin
      failed++;
      $display("FAIL midstream_reset: got %b required all 0",
               {wb_valid, wb_rd, wb_data, dmem_we, dmem_addr, dmem_wdata, stall, halted, imem_addr});
    end
    we0 = we_cnt;
    repeat (3) @(negedge clk);
    tests++;
    if (we_cnt != we0) begin
      failed++;
      $display("FAIL midstream_no_we: got %0d strobes required 0", we_cnt - we0);
    end
    clear_imem();
    imem[0] = 16'h1D12; imem[1] = 16'hF000;
    start_prog();
    base = ret_rd.size();
    wait_halt(ok);
    tests++;
    if (!ok) begin failed++; $display("FAIL regclr_halt: halted got 0 required 1"); end
    tests++;
    if (ret_rd.size() - base != 1) begin
      failed++;
      $display("FAIL regclr_count: got %0d required 1", ret_rd.size() - base);
    end else if (ret_rd[base] !== exp_rd[0] || ret_data[base] !== exp_d[0]) begin
      failed++;
      $display("FAIL regclr_value: got r%0d=%0d required r13=0", ret_rd[base], ret_data[base]);
    end
  endtask

  initial begin
    tests = 0; failed = 0; stall_cnt = 0; we_cnt = 0;
    rst = 1'b1; dm_load = 1'b1;
    for (int i = 0; i < 16; i++) dm_init[i] = 8'd0;
    dm_init[0] = 8'd200; dm_init[1] = 8'd100; dm_init[2] = 8'd5; dm_init[3] = 8'd7;
    clear_imem();
    test_reset();
    test_load_use();
    test_wrap_logic();
    test_jump_store();
    test_halt();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
